moore_seq_detector: RTL

//   Parametrised Moore serial pattern detector, successor to the 2-state Moore FSM.

---
 rtl/moore_seq_detector.sv | 127 ++++++++++++
 1 files changed

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector: tracks the longest matched prefix of PATTERN
// (KMP failure rule), raises out while the full pattern is matched, counts matches.
module moore_seq_detector #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in,
    input  logic                       clr_cnt,
    output logic                       out,
    output logic [$clog2(PAT_W+1)-1:0] state_o,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       cnt_sat
);

    localparam int SW = $clog2(PAT_W + 1);

    typedef logic [SW-1:0] state_t;

    localparam state_t           S0       = {SW{1'b0}};
    localparam state_t           S_FULL   = SW'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_t           state_r;
    state_t           base_s;
    state_t           next_s;
    logic             hit_s;
    logic             out_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sat_r;

    // Longest pattern prefix that is a suffix of (prefix of length cur) followed by b.
    function automatic state_t kmp_next(input state_t cur, input logic b);
        int   k;
        int   best;
        int   pos;
        logic ok;
        logic sbit;
        k    = int'(cur);
        best = 0;
        for (int j = 1; j <= PAT_W; j++) begin
            ok = (j <= k + 1);
            for (int i = 0; i < PAT_W; i++) begin
                if (ok && (i < j)) begin
                    pos = k + 1 - j + i;
                    if (pos == k) begin
                        sbit = b;
                    end else begin
                        sbit = PATTERN[PAT_W-1-pos];
                    end
                    if (sbit != PATTERN[PAT_W-1-i]) begin
                        ok = 1'b0;
                    end else begin
                        ok = ok;
                    end
                end else begin
                    ok = ok;
                end
            end
            if (ok) begin
                best = j;
            end else begin
                best = best;
            end
        end
        return best[SW-1:0];
    endfunction

    // Next-state decode; non-overlapping mode restarts from empty after a full match.
    always_comb begin
        base_s = state_r;
        if (state_r > S_FULL) begin
            base_s = S0;
        end else if ((state_r == S_FULL) && !OVERLAP) begin
            base_s = S0;
        end else begin
            base_s = state_r;
        end
        next_s = kmp_next(base_s, in);
        hit_s  = en && (next_s == S_FULL);
    end

    // State, registered match flag and saturating match counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S0;
            out_r   <= 1'b0;
            cnt_r   <= CNT_ZERO;
            sat_r   <= 1'b0;
        end else begin
            if (state_r > S_FULL) begin
                state_r <= S0;
                out_r   <= 1'b0;
            end else if (en) begin
                state_r <= next_s;
                out_r   <= (next_s == S_FULL);
            end else begin
                state_r <= state_r;
                out_r   <= out_r;
            end

            // Clear takes priority, so a coinciding match is dropped.
            if (clr_cnt) begin
                cnt_r <= CNT_ZERO;
                sat_r <= 1'b0;
            end else if (hit_s && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_ONE;
                sat_r <= sat_r | (cnt_r == (CNT_MAX - CNT_ONE));
            end else begin
                cnt_r <= cnt_r;
                sat_r <= sat_r;
            end
        end
    end

    assign out       = out_r;
    assign state_o   = state_r;
    assign match_cnt = cnt_r;
    assign cnt_sat   = sat_r;

endmodule
